// File: rtl/hamming_pkg.sv
// Shared constants, FSM encoding and Hamming(11,7) field helpers for the receive path.
package hamming_pkg;

  localparam int CW_W   = 11;
  localparam int DATA_W = 7;
  localparam int CHK_W  = 4;

  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    CHECK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Recompute check bits from the data positions and compare with the received ones.
  function automatic logic hamming_check(input logic [CW_W-1:0] cw);
    logic r1, r2, r4, r8;
    r1 = cw[10] ^ cw[8] ^ cw[6] ^ cw[4] ^ cw[2];
    r2 = cw[10] ^ cw[9] ^ cw[6] ^ cw[5] ^ cw[2];
    r4 = cw[6] ^ cw[5] ^ cw[4];
    r8 = cw[10] ^ cw[9] ^ cw[8];
    return ({cw[7], cw[3], cw[1], cw[0]} == {r8, r4, r2, r1});
  endfunction

  function automatic logic [DATA_W-1:0] hamming_data(input logic [CW_W-1:0] cw);
    return {cw[10:8], cw[6:4], cw[2]};
  endfunction

  function automatic logic [CHK_W-1:0] hamming_chk(input logic [CW_W-1:0] cw);
    return {cw[7], cw[3], cw[1], cw[0]};
  endfunction

endpackage

// File: rtl/hamming_sat_cnt.sv
// Saturating event counter with synchronous clear; clear has priority over increment.
module hamming_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/hamming_rx_ctrl.sv
// Serial Hamming(11,7) receive sequencer: assemble, check, hold for handshake, count.
module hamming_rx_ctrl
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_bit,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              rx_abort,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_chk,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  ok_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              stats_clr
);

  state_t            state, state_nxt;
  logic [3:0]        bit_cnt;
  logic [CW_W-1:0]   cw_p0;
  logic [DATA_W-1:0] data_p1;
  logic [CHK_W-1:0]  chk_p1;
  logic              err_p1;
  logic              vld_p1;
  logic              cw_ok;
  logic              ok_inc;
  logic              err_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SHIFT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    vld_p1    = 1'b0;
    case (state)
      SHIFT: begin
        rx_ready = 1'b1;
        if (!rx_abort && rx_valid && bit_cnt == 4'd10) state_nxt = CHECK;
      end
      CHECK: state_nxt = HOLD;
      HOLD: begin
        vld_p1 = 1'b1;
        if (out_ready) state_nxt = SHIFT;
      end
      default: state_nxt = SHIFT;
    endcase
  end

  // Stage p0: bit assembly; abort wins over a bit presented in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 4'd0;
      cw_p0   <= '0;
    end else if (state == SHIFT) begin
      if (rx_abort) begin
        bit_cnt <= 4'd0;
        cw_p0   <= '0;
      end else if (rx_valid) begin
        cw_p0   <= {cw_p0[CW_W-2:0], rx_bit};
        bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
      end
    end
  end

  assign cw_ok = hamming_check(cw_p0);

  // Stage p1: result registers, loaded once per codeword in CHECK and held through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      chk_p1  <= '0;
      err_p1  <= 1'b0;
    end else if (state == CHECK) begin
      data_p1 <= hamming_data(cw_p0);
      chk_p1  <= hamming_chk(cw_p0);
      err_p1  <= ~cw_ok;
    end
  end

  assign out_data  = data_p1;
  assign out_chk   = chk_p1;
  assign out_err   = err_p1;
  assign out_valid = vld_p1;

  assign ok_inc  = (state == CHECK) &&  cw_ok;
  assign err_inc = (state == CHECK) && !cw_ok;

  hamming_sat_cnt #(.CNT_W(CNT_W)) u_ok_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ok_inc),
    .clr   (stats_clr),
    .cnt   (ok_cnt)
  );

  hamming_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .clr   (stats_clr),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Directed self-checking bench for hamming_rx_ctrl.
module tb_hamming_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_bit;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_abort;
  logic [6:0] out_data;
  logic [3:0] out_chk;
  logic       out_err;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] ok_cnt;
  logic [7:0] err_cnt;
  logic       stats_clr;

  int n_cmp = 0;
  int n_bad = 0;

  hamming_rx_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_bit    (rx_bit),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_abort  (rx_abort),
    .out_data  (out_data),
    .out_chk   (out_chk),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ok_cnt    (ok_cnt),
    .err_cnt   (err_cnt),
    .stats_clr (stats_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents the first n bits of cw, MSB first, one per cycle.
  task automatic shift_bits(input logic [10:0] cw, input int n);
    for (int i = 10; i > 10 - n; i--) begin
      rx_valid = 1'b1;
      rx_bit   = cw[i];
      tick();
    end
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++; if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rx_ready got %b want 1", rx_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if ({out_data, out_chk, out_err} !== 12'h000) begin n_bad++; $display("FAIL reset_outputs got %h/%b/%b want 0", out_data, out_chk, out_err); end
    n_cmp++; if ({ok_cnt, err_cnt} !== 16'h0000) begin n_bad++; $display("FAIL reset_counters got %h/%h want 0", ok_cnt, err_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ok_word();
    out_ready = 1'b1;
    shift_bits(11'h483, 11);
    n_cmp++; if (rx_ready !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL ok_check_cycle got rdy=%b vld=%b want 0/0", rx_ready, out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ok_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 7'h40) begin n_bad++; $display("FAIL ok_data got %h want 40", out_data); end
    n_cmp++; if (out_chk !== 4'b1011) begin n_bad++; $display("FAIL ok_chk got %b want 1011", out_chk); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL ok_err got %b want 0", out_err); end
    n_cmp++; if (ok_cnt !== 8'd1 || err_cnt !== 8'd0) begin n_bad++; $display("FAIL ok_counts got %0d/%0d want 1/0", ok_cnt, err_cnt); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || rx_ready !== 1'b1) begin n_bad++; $display("FAIL ok_pulse_end got vld=%b rdy=%b want 0/1", out_valid, rx_ready); end
  endtask

  task automatic test_err_word();
    out_ready = 1'b1;
    shift_bits(11'h4A3, 11);
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL err_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 7'h44) begin n_bad++; $display("FAIL err_data got %h want 44", out_data); end
    n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL err_flag got %b want 1", out_err); end
    n_cmp++; if (err_cnt !== 8'd1 || ok_cnt !== 8'd1) begin n_bad++; $display("FAIL err_counts got ok=%0d err=%0d want 1/1", ok_cnt, err_cnt); end
    tick();
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    shift_bits(11'h000, 11);
    tick();
    rx_valid = 1'b1;
    rx_bit   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (out_valid !== 1'b1 || rx_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_%0d got vld=%b rdy=%b want 1/0", c, out_valid, rx_ready); end
      n_cmp++; if (out_data !== 7'h00 || out_chk !== 4'h0 || out_err !== 1'b0) begin n_bad++; $display("FAIL bp_stable_%0d got %h/%b/%b want 00/0000/0", c, out_data, out_chk, out_err); end
      tick();
    end
    rx_valid  = 1'b0;
    rx_bit    = 1'b0;
    out_ready = 1'b1;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_sixth got %b want 1", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || rx_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release got vld=%b rdy=%b want 0/1", out_valid, rx_ready); end
    n_cmp++; if (ok_cnt !== 8'd2) begin n_bad++; $display("FAIL bp_ok_cnt got %0d want 2", ok_cnt); end
  endtask

  task automatic test_abort();
    int pulses;
    out_ready = 1'b1;
    shift_bits(11'h7FF, 6);
    rx_abort = 1'b1;
    rx_valid = 1'b1;
    rx_bit   = 1'b1;
    tick();
    rx_abort = 1'b0;
    rx_valid = 1'b0;
    pulses = 0;
    for (int i = 10; i >= 0; i--) begin
      rx_valid = 1'b1;
      rx_bit   = 11'h483 >> i;
      tick();
      if (out_valid === 1'b1 || rx_ready !== 1'b1) pulses++;
      if (i == 0) pulses = (rx_ready === 1'b0) ? pulses : pulses + 100;
    end
    rx_valid = 1'b0;
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL abort_alignment got %0d want 1", pulses); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 7'h40 || out_err !== 1'b0) begin n_bad++; $display("FAIL abort_word got vld=%b %h err=%b want 1 40 0", out_valid, out_data, out_err); end
    n_cmp++; if (ok_cnt !== 8'd3 || err_cnt !== 8'd1) begin n_bad++; $display("FAIL abort_counts got %0d/%0d want 3/1", ok_cnt, err_cnt); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_single got %b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int k = 1; k <= 259; k++) begin
      shift_bits(11'h4A3, 11);
      tick();
      tick();
      if (k == 200) begin
        n_cmp++; if (err_cnt !== 8'd201) begin n_bad++; $display("FAIL sat_mid got %0d want 201", err_cnt); end
      end
    end
    n_cmp++; if (err_cnt !== 8'hFF) begin n_bad++; $display("FAIL sat_hold got %h want ff", err_cnt); end
    n_cmp++; if (ok_cnt !== 8'd3) begin n_bad++; $display("FAIL sat_ok got %0d want 3", ok_cnt); end
    shift_bits(11'h483, 11);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    n_cmp++; if (ok_cnt !== 8'd0 || err_cnt !== 8'd0) begin n_bad++; $display("FAIL clr_wins got %0d/%0d want 0/0", ok_cnt, err_cnt); end
    n_cmp++; if (out_valid !== 1'b1 || out_err !== 1'b0) begin n_bad++; $display("FAIL clr_word got vld=%b err=%b want 1/0", out_valid, out_err); end
    tick();
  endtask

  task automatic test_reset_in_hold();
    int spurious;
    out_ready = 1'b0;
    shift_bits(11'h483, 11);
    tick();
    n_cmp++; if (out_valid !== 1'b1 || ok_cnt !== 8'd1) begin n_bad++; $display("FAIL rh_pre got vld=%b ok=%0d want 1/1", out_valid, ok_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rh_async_valid got %b want 0", out_valid); end
    n_cmp++; if ({out_data, out_chk, out_err, ok_cnt, err_cnt} !== 28'h0) begin n_bad++; $display("FAIL rh_async_zero got %h/%b/%b/%0d/%0d want all 0", out_data, out_chk, out_err, ok_cnt, err_cnt); end
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    spurious  = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid !== 1'b0 || rx_ready !== 1'b1) spurious++;
    end
    n_cmp++; if (spurious !== 0) begin n_bad++; $display("FAIL rh_post got %0d bad cycles want 0", spurious); end
    n_cmp++; if (ok_cnt !== 8'd0 || err_cnt !== 8'd0) begin n_bad++; $display("FAIL rh_counts got %0d/%0d want 0/0", ok_cnt, err_cnt); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_bit    = 1'b0;
    rx_valid  = 1'b0;
    rx_abort  = 1'b0;
    out_ready = 1'b0;
    stats_clr = 1'b0;
    test_reset();
    test_ok_word();
    test_err_word();
    test_back_pressure();
    test_abort();
    test_saturation();
    test_reset_in_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
